// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state enumeration and default width for serial_subtractor
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdder.sv
// rtl/FullAdder.sv - one-bit full adder
module FullAdder (
  input  logic i_A,
  input  logic i_B,
  input  logic i_Cin,
  output logic o_Sum,
  output logic o_Cout
);

  assign o_Sum  = i_A ^ i_B ^ i_Cin;
  assign o_Cout = (i_A & i_B) | (i_Cin & (i_A ^ i_B));

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B (A + ~B + 1) with valid/ready handshakes
// Optional signed-overflow flag o_Ovf enabled by macro SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Diff,
  output logic             o_Borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             o_Ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  FullAdder u_fa (
    .i_A    (a_sh[0]),
    .i_B    (b_sh[0]),
    .i_Cin  (carry),
    .o_Sum  (fa_sum),
    .o_Cout (fa_cout)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_Ready   = 1'b0;
    o_Valid   = 1'b0;
    case (state)
      IDLE: begin
        o_Ready = 1'b1;
        if (i_Valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST_BIT) state_nxt = DONE;
      end
      DONE: begin
        o_Valid = 1'b1;
        if (i_Ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtrahend is stored inverted and carry starts at 1, so the adder computes A + ~B + 1.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      o_Diff   <= '0;
      o_Borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_Valid) begin
            a_sh  <= i_A;
            b_sh  <= ~i_B;
            carry <= 1'b1;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          o_Diff <= {fa_sum, o_Diff[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
          if (cnt == LAST_BIT) o_Borrow <= ~fa_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // On the MSB step the carry register holds the carry into the MSB.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Ovf <= 1'b0;
    end else if (state == RUN && cnt == LAST_BIT) begin
      o_Ovf <= carry ^ fa_cout;
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor (WIDTH=4)
module tb_serial_subtractor;

  localparam int W = 4;

  logic         i_Clk = 1'b0;
  logic         i_Rst;
  logic         i_Valid;
  logic         o_Ready;
  logic [W-1:0] i_A;
  logic [W-1:0] i_B;
  logic         o_Valid;
  logic         i_Ready;
  logic [W-1:0] o_Diff;
  logic         o_Borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         o_Ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Valid  (i_Valid),
    .o_Ready  (o_Ready),
    .i_A      (i_A),
    .i_B      (i_B),
    .o_Valid  (o_Valid),
    .i_Ready  (i_Ready),
    .o_Diff   (o_Diff),
    .o_Borrow (o_Borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .o_Ovf    (o_Ovf)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  // Reference: plain integer subtraction, unsigned compare, signed range test.
  function automatic void model(input int a, input int b, output logic [W-1:0] d,
                                output logic br, output logic ov);
    int sa, sb, s;
    d  = W'(a - b);
    br = (a < b);
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    s  = sa - sb;
    ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endfunction

  task automatic run_op(input int a, input int b, output logic [W-1:0] d, output logic br,
                        output logic ov, output int lat);
    int guard = 0;
    @(negedge i_Clk);
    while (!o_Ready && guard < 50) begin
      @(negedge i_Clk);
      guard++;
    end
    i_A = W'(a);
    i_B = W'(b);
    i_Valid = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    lat = 0;
    while (!o_Valid && lat < 50) begin
      @(negedge i_Clk);
      lat++;
    end
    d  = o_Diff;
    br = o_Borrow;
    ov = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ov = o_Ovf;
`endif
    i_Ready = 1'b1;
    @(negedge i_Clk);
    i_Ready = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst = 1'b1; i_Valid = 1'b0; i_Ready = 1'b0; i_A = '0; i_B = '0;
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    total++; if (o_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_Ready); end
    total++; if (o_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_Valid); end
    total++; if (o_Diff !== '0) begin bad++; $display("FAIL reset_diff got=%h exp=0", o_Diff); end
    total++; if (o_Borrow !== 1'b0) begin bad++; $display("FAIL reset_borrow got=%b exp=0", o_Borrow); end
  endtask

  task automatic test_directed();
    int ta [3] = '{9, 3, 5};
    int tb [3] = '{3, 9, 5};
    logic [W-1:0] d, ed;
    logic br, ebr, ov, eov;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], d, br, ov, lat);
      model(ta[i], tb[i], ed, ebr, eov);
      total++; if (d !== ed) begin bad++; $display("FAIL dir_diff %0d-%0d got=%h exp=%h", ta[i], tb[i], d, ed); end
      total++; if (br !== ebr) begin bad++; $display("FAIL dir_borrow %0d-%0d got=%b exp=%b", ta[i], tb[i], br, ebr); end
      total++; if (lat != W) begin bad++; $display("FAIL dir_latency %0d-%0d got=%0d exp=%0d", ta[i], tb[i], lat, W); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, ed;
    logic br, ebr, ov, eov;
    int lat, a, b;
    for (int i = 0; i < 20; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      run_op(a, b, d, br, ov, lat);
      model(a, b, ed, ebr, eov);
      total++; if (d !== ed || br !== ebr || lat != W) begin
        bad++;
        $display("FAIL rand %0d-%0d got diff=%h borrow=%b lat=%0d exp diff=%h borrow=%b lat=%0d",
                 a, b, d, br, lat, ed, ebr, W);
      end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      total++; if (ov !== eov) begin bad++; $display("FAIL rand_ovf %0d-%0d got=%b exp=%b", a, b, ov, eov); end
`endif
    end
  endtask

  task automatic test_valid_ignored();
    int guard = 0;
    @(negedge i_Clk);
    i_A = 4'd9; i_B = 4'd3; i_Valid = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_A = 4'd1; i_B = 4'd0;
    while (!o_Valid && guard < 50) begin @(negedge i_Clk); guard++; end
    repeat (3) @(negedge i_Clk);
    total++; if (o_Valid !== 1'b1 || o_Diff !== 4'd6) begin
      bad++; $display("FAIL ign_hold got valid=%b diff=%h exp valid=1 diff=6", o_Valid, o_Diff);
    end
    i_Ready = 1'b1;
    @(negedge i_Clk);
    i_Ready = 1'b0;
    total++; if (o_Ready !== 1'b1 || o_Valid !== 1'b0 || o_Diff !== 4'd6) begin
      bad++; $display("FAIL ign_idle got ready=%b valid=%b diff=%h exp 1 0 6", o_Ready, o_Valid, o_Diff);
    end
    @(negedge i_Clk);
    i_Valid = 1'b0;
    guard = 0;
    while (!o_Valid && guard < 50) begin @(negedge i_Clk); guard++; end
    total++; if (o_Diff !== 4'd1 || o_Borrow !== 1'b0) begin
      bad++; $display("FAIL ign_second got diff=%h borrow=%b exp diff=1 borrow=0", o_Diff, o_Borrow);
    end
    i_Ready = 1'b1;
    @(negedge i_Clk);
    i_Ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    @(negedge i_Clk);
    i_A = 4'd9; i_B = 4'd3; i_Valid = 1'b1;
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Valid = 1'b0;
    @(negedge i_Clk);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    total++; if (o_Ready !== 1'b1 || o_Diff !== '0 || o_Borrow !== 1'b0) begin
      bad++; $display("FAIL rst_run got ready=%b diff=%h borrow=%b exp 1 0 0", o_Ready, o_Diff, o_Borrow);
    end
    for (int i = 0; i < 10; i++) begin
      if (o_Valid) seen++;
      @(negedge i_Clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rst_novalid got=%0d exp=0", seen); end
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] d;
    logic br, ov;
    int lat;
    run_op(7, 15, d, br, ov, lat);
    total++; if (d !== 4'd8 || ov !== 1'b1) begin bad++; $display("FAIL ovf_set got diff=%h ovf=%b exp 8 1", d, ov); end
    run_op(9, 3, d, br, ov, lat);
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ov); end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [$];
    logic [W-1:0] d;
    logic br, ov, prev_v;
    int pushed = 0, popped = 0, cyc = 0, a, b;
    i_Ready = 1'b1;
    prev_v  = 1'b0;
    while (popped < 5 && cyc < 200) begin
      @(negedge i_Clk);
      cyc++;
      if (o_Valid) begin
        total++; if (prev_v) begin bad++; $display("FAIL b2b_onecycle valid held 2 cycles at cyc=%0d", cyc); end
        total++; if (exp_q.size() == 0 || o_Diff !== exp_q[0]) begin
          bad++; $display("FAIL b2b_diff got=%h exp=%h", o_Diff, (exp_q.size() != 0) ? exp_q[0] : 'x);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      prev_v = o_Valid;
      if (o_Ready) begin
        if (pushed < 5) begin
          a = int'($urandom_range(0, (1 << W) - 1));
          b = int'($urandom_range(0, (1 << W) - 1));
          i_A = W'(a); i_B = W'(b); i_Valid = 1'b1;
          model(a, b, d, br, ov);
          exp_q.push_back(d);
          pushed++;
        end else begin
          i_Valid = 1'b0;
        end
      end
    end
    i_Valid = 1'b0;
    i_Ready = 1'b0;
    total++; if (popped != 5) begin bad++; $display("FAIL b2b_count got=%0d exp=5", popped); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_valid_ignored();
    test_reset_mid_run();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (WIDTH >= 2).
REQ-002 The module SHALL have port i_Clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port i_Rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port i_Valid  input  1  operands present on i_A/i_B.
REQ-005 The module SHALL have port o_Ready  output  1  the module accepts operands this cycle.
REQ-006 The module SHALL have port i_A  input  WIDTH  minuend.
REQ-007 The module SHALL have port i_B  input  WIDTH  subtrahend.
REQ-008 The module SHALL have port o_Valid  output  1  result held and valid.
REQ-009 The module SHALL have port i_Ready  input  1  consumer takes the result.
REQ-010 The module SHALL have port o_Diff  output  WIDTH  A minus B, modulo 2^WIDTH.
REQ-011 The module SHALL have port o_Borrow  output  1  1 when unsigned A < B.

Function
REQ-012 The module SHALL have states IDLE, RUN and DONE.
REQ-013 o_Ready SHALL be 1 only in IDLE, and o_Valid SHALL be 1 only in DONE.
REQ-014 At an edge with IDLE && i_Valid, the module SHALL capture i_A, and ~i_B into shift registers, set the carry register to 1, clear the bit counter and enter RUN.
REQ-015 In RUN, each edge SHALL add operand bit 0 and inverted-subtrahend bit 0 with the carry register, shift the sum bit into the result register MSB-first (LSB ends at bit 0), right-shift both operands and update the carry.
REQ-016 After exactly WIDTH RUN edges the module SHALL enter DONE; o_Valid SHALL be high WIDTH+1 cycles after the accept edge.
REQ-017 o_Borrow SHALL equal the inverse of the final carry-out.
REQ-018 o_Diff and o_Borrow SHALL be held stable throughout DONE.
REQ-019 At an edge with DONE && i_Ready, the module SHALL return to IDLE.
REQ-020 o_Diff and o_Borrow SHALL keep their last value in IDLE until the next accept edge.
REQ-021 i_Valid in RUN or DONE SHALL be ignored, with no capture and no state change.
REQ-022 i_Ready outside DONE SHALL be ignored.
REQ-023 If i_Valid and i_Ready are both high in DONE, only the return to IDLE SHALL occur; the new operand SHALL be accepted no earlier than the following edge.

Reset
REQ-024 With i_Rst high at an edge, the state SHALL become IDLE and o_Diff, o_Borrow, the carry, the counter and the operand registers SHALL become 0, so o_Ready=1 and o_Valid=0 on the next cycle.
REQ-025 Reset SHALL override all other events, including mid-RUN, and an aborted operation SHALL produce no o_Valid.

Configuration
REQ-026 With macro SERIAL_SUBTRACTOR_OVF_EN defined, the module SHALL have an extra output o_Ovf (1 bit) that is 1 in DONE when the signed two's-complement result overflowed (carry into MSB xor carry out of MSB).
REQ-027 o_Ovf SHALL be reset to 0 and held like o_Diff.
REQ-028 Without the macro, o_Ovf and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-029 A shared package SHALL hold the state enumeration typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-030 The per-bit arithmetic SHALL instantiate the team's existing FullAdder sub-module once, with ports i_A, i_B, i_Cin, o_Sum and o_Cout; no other sub-module SHALL be used.
REQ-031 The bit counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=4)
REQ-032 The bench SHALL check: A=9, B=3 -> o_Diff=6, o_Borrow=0, o_Valid at cycle 5 after accept.
REQ-033 The bench SHALL check: A=3, B=9 -> o_Diff=0xA, o_Borrow=1; A=5, B=5 -> o_Diff=0, o_Borrow=0.
REQ-034 The bench SHALL check: i_Valid with A=1 asserted during RUN and held through DONE with i_Ready=0 -> first result unchanged, no second accept until after IDLE.
REQ-035 The bench SHALL check: i_Rst pulsed at the 2nd RUN edge -> IDLE, o_Ready=1, o_Diff=0, no o_Valid pulse.
REQ-036 The bench SHALL check, with the macro defined: A=7, B=0xF (-1) -> o_Diff=8, o_Ovf=1; A=9, B=3 -> o_Ovf=0.
REQ-037 The bench SHALL check: back-to-back operations with i_Ready held high -> each result present for exactly one DONE cycle.
